// File: rtl/pll_lock_reset_seq_if.sv
// Signal bundle between the PLL reset sequencer and its PLL/system-reset consumers.
// The slave side is the sequencer; the master side drives locked_in and observes the rest.
interface pll_lock_reset_seq_if;
  logic       locked_in;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [2:0] state;

  modport master (
    output locked_in,
    input  pll_rst, sys_rst, ready, fault, retry_cnt, lock_loss_cnt, state
  );

  modport slave (
    input  locked_in,
    output pll_rst, sys_rst, ready, fault, retry_cnt, lock_loss_cnt, state
  );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a qualified lock with bounded
// retries, then releases system reset; any lock loss in RUN restarts the whole sequence.
module pll_lock_reset_seq #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES    = 7,
  parameter int CNT_W          = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_reset_seq_if.slave  io
);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] PRC_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LT_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SC_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

  logic             sync1_q, locked_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             give_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      state_q    <= S_PLL_RST;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync1_q    <= io.locked_in;
      locked_s_q <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      pll_rst_q  <= pll_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    give_up = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PRC_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s_q) begin
          cnt_d   = '0;
          state_d = S_STABLE;
        end else if (cnt_q == LT_LAST) begin
          give_up = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!locked_s_q) begin
          give_up = 1'b1;
        end else if (cnt_q == SC_LAST) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
        if (!locked_s_q) begin
          loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
          retry_d = '0;
          cnt_d   = '0;
          state_d = S_PLL_RST;
        end
      end
      S_FAULT: ;
      default: state_d = S_FAULT;
    endcase
    // Timeouts and STABLE dropouts share one retry budget so a flaky lock still ends in FAULT.
    if (give_up) begin
      cnt_d = '0;
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAULT;
      end else begin
        retry_d = retry_q + 3'd1;
        state_d = S_PLL_RST;
      end
    end
  end

  // Outputs are decoded from the next state so they register on the same edge as the state.
  always_comb begin
    pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  assign io.pll_rst       = pll_rst_q;
  assign io.sys_rst       = sys_rst_q;
  assign io.ready         = ready_q;
  assign io.fault         = fault_q;
  assign io.retry_cnt     = retry_q;
  assign io.lock_loss_cnt = loss_q;
  assign io.state         = state_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed bring-up scenarios plus randomized lock activity,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pll_lock_reset_seq;
  localparam int PRC = 4;
  localparam int LT  = 20;
  localparam int SC  = 8;
  localparam int MR  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  pll_lock_reset_seq_if io();

  pll_lock_reset_seq #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MR),
    .CNT_W         (17)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  // Model: phase 0..4 (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT), cycles elapsed in phase,
  // retries, losses, and a two-deep delay line standing in for the synchronizer.
  int m_mode, m_el, m_retry, m_loss;
  bit m_s1, m_s2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic retry_or_fault();
    if (m_retry == MR) m_mode = 4;
    else begin
      m_retry++;
      m_mode = 0;
      m_el   = 0;
    end
  endtask

  task automatic model_edge(input bit r, input bit lin);
    bit ls;
    if (r) begin
      m_mode = 0; m_el = 0; m_retry = 0; m_loss = 0; m_s1 = 0; m_s2 = 0;
      return;
    end
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = lin;
    case (m_mode)
      0: begin
        m_el++;
        if (m_el == PRC) begin m_mode = 1; m_el = 0; end
      end
      1: begin
        if (ls) begin m_mode = 2; m_el = 0; end
        else begin
          m_el++;
          if (m_el == LT) retry_or_fault();
        end
      end
      2: begin
        if (!ls) retry_or_fault();
        else begin
          m_el++;
          if (m_el == SC) begin m_mode = 3; m_el = 0; end
        end
      end
      3: begin
        if (!ls) begin
          if (m_loss < 255) m_loss++;
          m_retry = 0; m_mode = 0; m_el = 0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_model();
    chk("model_state",   io.state,         m_mode);
    chk("model_pll_rst", io.pll_rst,       (m_mode == 0 || m_mode == 4));
    chk("model_sys_rst", io.sys_rst,       (m_mode != 3));
    chk("model_ready",   io.ready,         (m_mode == 3));
    chk("model_fault",   io.fault,         (m_mode == 4));
    chk("model_retry",   io.retry_cnt,     m_retry);
    chk("model_loss",    io.lock_loss_cnt, m_loss);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(rst, io.locked_in);
    #1;
    compare_model();
  endtask

  task automatic wait_state(input int s, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (io.state !== 3'(s) && n < limit);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"},   io.state,         0);
    chk({tag, "_pll_rst"}, io.pll_rst,       1);
    chk({tag, "_sys_rst"}, io.sys_rst,       1);
    chk({tag, "_ready"},   io.ready,         0);
    chk({tag, "_fault"},   io.fault,         0);
    chk({tag, "_retry"},   io.retry_cnt,     0);
    chk({tag, "_loss"},    io.lock_loss_cnt, 0);
  endtask

  initial begin
    int n, hi, waits, entries, hold;
    logic [2:0] prev;
    bit lvl;

    // Reset and startup pulse
    io.locked_in = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk_reset_values("reset");
    rst = 1'b0;
    wait_state(1, 50, n);
    chk("startup_pulse_edges", n, PRC);
    chk("startup_pll_rst_low", io.pll_rst, 0);

    // Clean lock
    repeat ($urandom_range(0, 10)) tick();
    io.locked_in = 1'b1;
    wait_state(3, 100, n);
    chk("release_edges", n, SC + 3);
    chk("release_ready", io.ready, 1);
    chk("release_sys_rst", io.sys_rst, 0);
    chk("release_retry", io.retry_cnt, 0);

    // Lock loss in RUN
    repeat ($urandom_range(1, 20)) tick();
    io.locked_in = 1'b0;
    n = 0;
    do begin tick(); n++; end while (io.sys_rst !== 1'b1 && n < 20);
    chk("loss_edges", n, 3);
    chk("loss_count", io.lock_loss_cnt, 1);
    chk("loss_retry", io.retry_cnt, 0);
    chk("loss_pll_rst", io.pll_rst, 1);
    hi = 1;
    while (io.pll_rst === 1'b1 && hi < 50) begin
      tick();
      if (io.pll_rst === 1'b1) hi++;
    end
    chk("loss_pulse_len", hi, PRC);
    io.locked_in = 1'b1;
    wait_state(3, 100, n);
    chk("loss_relock_ready", io.ready, 1);

    // One-cycle dropout at STABLE counter 5
    io.locked_in = 1'b0;
    wait_state(1, 100, n);
    io.locked_in = 1'b1;
    wait_state(2, 50, n);
    repeat (3) tick();
    io.locked_in = 1'b0;
    tick();
    io.locked_in = 1'b1;
    tick();
    tick();
    chk("dropout_state", io.state, 0);
    chk("dropout_retry", io.retry_cnt, 1);
    chk("dropout_sys_rst", io.sys_rst, 1);
    wait_state(3, 100, n);
    chk("dropout_relock_ready", io.ready, 1);
    chk("dropout_relock_retry", io.retry_cnt, 1);

    // Timeout retries to FAULT
    rst = 1'b1;
    io.locked_in = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    waits = 0; entries = 0; n = 0;
    prev = io.state;
    while (io.fault !== 1'b1 && n < 500) begin
      tick();
      n++;
      if (io.state === 3'd1) waits++;
      if (io.state === 3'd1 && prev !== 3'd1) entries++;
      prev = io.state;
    end
    chk("fault_wait_entries", entries, MR + 1);
    chk("fault_wait_cycles", waits, (MR + 1) * LT);
    chk("fault_flag", io.fault, 1);
    chk("fault_state", io.state, 4);
    chk("fault_retry", io.retry_cnt, MR);
    chk("fault_pll_rst", io.pll_rst, 1);
    chk("fault_sys_rst", io.sys_rst, 1);

    // FAULT ignores lock activity, reset clears it
    for (int i = 0; i < 30; i++) begin
      io.locked_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("fault_hold_state", io.state, 4);
    rst = 1'b1;
    tick();
    chk_reset_values("fault_reset");
    rst = 1'b0;

    // Randomized lock behaviour with occasional resets
    hold = 0;
    lvl  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        lvl  = ($urandom_range(0, 99) < 70);
        hold = $urandom_range(1, 40);
      end
      hold--;
      io.locked_in = lvl;
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;

    // Loss counter saturation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      io.locked_in = 1'b1;
      wait_state(3, 100, n);
      io.locked_in = 1'b0;
      wait_state(0, 20, n);
    end
    chk("loss_saturated", io.lock_loss_cnt, 255);
    io.locked_in = 1'b1;
    wait_state(3, 100, n);
    chk("sat_relock_ready", io.ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
